// File: rtl/time_disp_scan.sv
// time_disp_scan: six-digit multiplexed 7-segment scanner for the RTC block.
// A snapshot of hr/mn/sc/blink_sel is taken once per frame, so a frame never
// mixes two different seconds. Each field becomes two BCD digits. The field
// under edit blinks on a slow phase taken from the frame counter.
module time_disp_scan #(
    parameter int SCAN_DIV = 1024,
    parameter int BLINK_SH = 5,
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hr,
    input  logic [5:0] mn,
    input  logic [5:0] sc,
    input  logic [2:0] blink_sel,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int          FW        = BLINK_SH + 1;
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    logic [15:0]   scanCnt_q,     scanCnt_d;
    logic [2:0]    digit_q,       digit_d;
    logic [FW-1:0] frameCnt_q,    frameCnt_d;
    logic [4:0]    snapHr_q,      snapHr_d;
    logic [5:0]    snapMn_q,      snapMn_d;
    logic [5:0]    snapSc_q,      snapSc_d;
    logic [2:0]    snapBlink_q,   snapBlink_d;
    logic          loadPending_q, loadPending_d;

    logic [5:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;
    logic       frameStart_d;

    logic       scanWrap;
    logic       endOfFrame;
    logic       loadNow;
    logic [5:0] fieldVal;
    logic       fieldValid;
    logic [2:0] fieldSel;
    logic [3:0] digitVal;
    logic       blinkOn;

    // Tens digit of a 0..59 value via a compare ladder (no divider).
    function automatic logic [3:0] bcdTens(input logic [5:0] v);
        if (v >= 6'd50)      return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    // Ones digit: subtract ten times the tens digit.
    function automatic logic [3:0] bcdOnes(input logic [5:0] v);
        logic [5:0] t;
        t = {2'b00, bcdTens(v)};
        return 4'(v - t * 6'd10);
    endfunction

    // Segment pattern {g,f,e,d,c,b,a} for a decimal digit.
    function automatic logic [6:0] segPattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Scan, digit and frame counters plus snapshot load decision.
    // The counters stay frozen until the first snapshot after reset has loaded.
    always_comb begin
        scanWrap      = (scanCnt_q == SCAN_LAST);
        endOfFrame    = (digit_q == 3'd5) && scanWrap;
        loadNow       = loadPending_q || endOfFrame;
        scanCnt_d     = scanCnt_q;
        digit_d       = digit_q;
        frameCnt_d    = frameCnt_q;
        loadPending_d = 1'b0;
        if (!loadPending_q) begin
            scanCnt_d = scanWrap ? 16'd0 : scanCnt_q + 16'd1;
            if (scanWrap) begin
                digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
            end
            if (endOfFrame) begin
                frameCnt_d = frameCnt_q + FW'(1);
            end
        end
        snapHr_d     = loadNow ? hr        : snapHr_q;
        snapMn_d     = loadNow ? mn        : snapMn_q;
        snapSc_d     = loadNow ? sc        : snapSc_q;
        snapBlink_d  = loadNow ? blink_sel : snapBlink_q;
        frameStart_d = loadNow;
    end

    // Decode the currently indexed digit from the snapshot into an/seg/dp.
    // Priority: blink blanking, then out-of-range dash, then hour leading zero.
    always_comb begin
        fieldVal   = 6'd0;
        fieldValid = 1'b0;
        fieldSel   = 3'b000;
        case (digit_q)
            3'd0, 3'd1: begin
                fieldVal   = snapSc_q;
                fieldValid = (snapSc_q <= 6'd59);
                fieldSel   = 3'b001;
            end
            3'd2, 3'd3: begin
                fieldVal   = snapMn_q;
                fieldValid = (snapMn_q <= 6'd59);
                fieldSel   = 3'b010;
            end
            default: begin
                fieldVal   = {1'b0, snapHr_q};
                fieldValid = (snapHr_q <= 5'd23);
                fieldSel   = 3'b100;
            end
        endcase
        digitVal = digit_q[0] ? bcdTens(fieldVal) : bcdOnes(fieldVal);
        blinkOn  = frameCnt_q[BLINK_SH] && (snapBlink_q == fieldSel);

        if (blinkOn) begin
            seg_d = 7'h00;
        end else if (!fieldValid) begin
            seg_d = 7'h40;
        end else if ((digit_q == 3'd5) && (BLANK_LZ != 0) && (snapHr_q < 5'd10)) begin
            seg_d = 7'h00;
        end else begin
            seg_d = segPattern(digitVal);
        end
        an_d = 6'b000001 << digit_q;
        dp_d = (digit_q == 3'd2) || (digit_q == 3'd4);

        if (loadPending_q) begin
            an_d  = 6'd0;
            seg_d = 7'h00;
            dp_d  = 1'b0;
        end
    end

    // Counter and snapshot state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scanCnt_q     <= 16'd0;
            digit_q       <= 3'd0;
            frameCnt_q    <= '0;
            snapHr_q      <= 5'd0;
            snapMn_q      <= 6'd0;
            snapSc_q      <= 6'd0;
            snapBlink_q   <= 3'd0;
            loadPending_q <= 1'b1;
        end else begin
            scanCnt_q     <= scanCnt_d;
            digit_q       <= digit_d;
            frameCnt_q    <= frameCnt_d;
            snapHr_q      <= snapHr_d;
            snapMn_q      <= snapMn_d;
            snapSc_q      <= snapSc_d;
            snapBlink_q   <= snapBlink_d;
            loadPending_q <= loadPending_d;
        end
    end

    // Registered display outputs, one cycle behind the digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an          <= 6'd0;
            seg         <= 7'h00;
            dp          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
            frame_start <= frameStart_d;
        end
    end

endmodule

// File: tb/tb_time_disp_scan.sv
// tb_time_disp_scan: two scanner instances with different parameters share
// the same inputs; a timeline-based model predicts every output each cycle.
`timescale 1ns/100ps
module tb_time_disp_scan;

    localparam int SA = 4, SHA = 1, LZA = 1;
    localparam int SB = 2, SHB = 0, LZB = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] hr = 5'd12;
    logic [5:0] mn = 6'd34;
    logic [5:0] sc = 6'd56;
    logic [2:0] blinkSel = 3'b000;

    logic [5:0] anA, anB;
    logic [6:0] segA, segB;
    logic       dpA, dpB, fsA, fsB;

    int compared = 0;
    int mismatched = 0;
    int k = -1;
    int snapA[4];
    int snapB[4];
    int segTab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    time_disp_scan #(.SCAN_DIV(SA), .BLINK_SH(SHA), .BLANK_LZ(LZA)) dutA (
        .clk(clk), .rst(rst), .hr(hr), .mn(mn), .sc(sc), .blink_sel(blinkSel),
        .an(anA), .seg(segA), .dp(dpA), .frame_start(fsA)
    );

    time_disp_scan #(.SCAN_DIV(SB), .BLINK_SH(SHB), .BLANK_LZ(LZB)) dutB (
        .clk(clk), .rst(rst), .hr(hr), .mn(mn), .sc(sc), .blink_sel(blinkSel),
        .an(anB), .seg(segB), .dp(dpB), .frame_start(fsB)
    );

    // Free-running clock, 10 ns period.
    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    // Expected outputs at edge kk counted from the first edge after reset (E0).
    function automatic void model(input int S, input int SH, input int LZ, input int kk,
                                  input int sHr, input int sMn, input int sSc, input int sBl,
                                  output int eAn, output int eSeg, output int eDp, output int eFs);
        int j, d, f, v, lim, dv, sel;
        if (kk == 0) begin
            eAn = 0; eSeg = 0; eDp = 0; eFs = 1;
            return;
        end
        j   = kk - 1;
        d   = (j / S) % 6;
        f   = j / (6 * S);
        eFs = (kk % (6 * S) == 0) ? 1 : 0;
        eAn = 1 << d;
        eDp = (d == 2 || d == 4) ? 1 : 0;
        if (d < 2)      begin v = sSc; lim = 59; sel = 1; end
        else if (d < 4) begin v = sMn; lim = 59; sel = 2; end
        else            begin v = sHr; lim = 23; sel = 4; end
        dv = (d % 2 == 1) ? v / 10 : v % 10;
        if (((f >> SH) & 1) == 1 && sBl == sel) eSeg = 0;
        else if (v > lim)                       eSeg = 'h40;
        else if (d == 5 && LZ != 0 && v < 10)   eSeg = 0;
        else                                    eSeg = segTab[dv];
    endfunction

    // Per-cycle compare process: tracks edges since release, keeps each
    // instance's frame snapshot, and compares all outputs 1 ns after the edge.
    initial begin
        int aAn, aSeg, aDp, aFs, bAn, bSeg, bDp, bFs;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                k = -1;
                #0.2;
                checkOutput("rstA.an", anA, 0);  checkOutput("rstA.seg", segA, 0);
                checkOutput("rstA.dp", dpA, 0);  checkOutput("rstA.fs", fsA, 0);
                checkOutput("rstB.an", anB, 0);  checkOutput("rstB.seg", segB, 0);
                checkOutput("rstB.dp", dpB, 0);  checkOutput("rstB.fs", fsB, 0);
            end else begin
                k++;
                model(SA, SHA, LZA, k, snapA[0], snapA[1], snapA[2], snapA[3], aAn, aSeg, aDp, aFs);
                model(SB, SHB, LZB, k, snapB[0], snapB[1], snapB[2], snapB[3], bAn, bSeg, bDp, bFs);
                if (k % (6 * SA) == 0) snapA = '{int'(hr), int'(mn), int'(sc), int'(blinkSel)};
                if (k % (6 * SB) == 0) snapB = '{int'(hr), int'(mn), int'(sc), int'(blinkSel)};
                #1;
                checkOutput("A.an", anA, aAn);  checkOutput("A.seg", segA, aSeg);
                checkOutput("A.dp", dpA, aDp);  checkOutput("A.fs", fsA, aFs);
                checkOutput("B.an", anB, bAn);  checkOutput("B.seg", segB, bSeg);
                checkOutput("B.dp", dpB, bDp);  checkOutput("B.fs", fsB, bFs);
            end
        end
    end

    // Wait until edge n has been seen, then settle 2 ns past it.
    task automatic waitEdge(input int n);
        int guard = 0;
        while (k != n) begin
            if (guard > 500) begin
                checkOutput("waitEdge", k, n);
                return;
            end
            @(posedge clk);
            #2;
            guard++;
        end
    endtask

    task automatic applyStimulus(input int h, input int m, input int s, input int b);
        hr = 5'(h); mn = 6'(m); sc = 6'(s); blinkSel = 3'(b);
    endtask

    // Directed scenarios with hand-computed values, then randomized traffic.
    initial begin
        #3;
        checkOutput("lit.rst.an", anA, 0);
        checkOutput("lit.rst.fs", fsA, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        waitEdge(0);  checkOutput("lit.E0.fs", fsA, 1);  checkOutput("lit.E0.an", anA, 0);
        waitEdge(1);  checkOutput("lit.E1.an", anA, 'h01); checkOutput("lit.E1.seg", segA, 'h7D);
        applyStimulus(12, 34, 57, 0);
        waitEdge(5);  checkOutput("lit.sc10.an", anA, 'h02); checkOutput("lit.sc10.seg", segA, 'h6D);
        waitEdge(9);  checkOutput("lit.mn1.seg", segA, 'h66); checkOutput("lit.mn1.dp", dpA, 1);
        waitEdge(21); checkOutput("lit.hr10.an", anA, 'h20); checkOutput("lit.hr10.seg", segA, 'h06);
        waitEdge(24); checkOutput("lit.fs2", fsA, 1);
        waitEdge(25); checkOutput("lit.sc57.seg", segA, 'h07);
        applyStimulus(5, 34, 57, 0);
        waitEdge(47); checkOutput("lit.lz0.an", anB, 'h20); checkOutput("lit.lz0.seg", segB, 'h3F);
        waitEdge(70); checkOutput("lit.lz1.an", anA, 'h20); checkOutput("lit.lz1.seg", segA, 'h00);
        waitEdge(73);
        applyStimulus(5, 34, 57, 3'b010);
        waitEdge(85); checkOutput("lit.blkSc.seg", segB, 'h07);
        waitEdge(89); checkOutput("lit.blkOdd.an", anB, 'h04); checkOutput("lit.blkOdd.seg", segB, 'h00);
        checkOutput("lit.blkOdd.dp", dpB, 1);
        waitEdge(101); checkOutput("lit.blkEven.seg", segB, 'h66);
        waitEdge(110);
        applyStimulus(24, 34, 60, 3'b010);
        waitEdge(121); checkOutput("lit.dashSc.seg", segA, 'h40);
        waitEdge(129); checkOutput("lit.dashMn.seg", segA, 'h66);
        waitEdge(141); checkOutput("lit.dashHr.seg", segA, 'h40);
        applyStimulus(24, 34, 60, 0);

        waitEdge(158); checkOutput("lit.preRst.an", anA, 'h08);
        #1 rst = 1'b1;
        #0.5;
        checkOutput("lit.async.an", anA, 0);  checkOutput("lit.async.seg", segA, 0);
        checkOutput("lit.async.dp", dpA, 0);  checkOutput("lit.async.fs", fsA, 0);
        #0.5 rst = 1'b0;
        waitEdge(0); checkOutput("lit.reE0.fs", fsA, 1); checkOutput("lit.reE0.an", anA, 0);
        waitEdge(1); checkOutput("lit.reE1.an", anA, 'h01); checkOutput("lit.reE1.seg", segA, 'h40);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            if ($urandom % 16 == 0) begin
                applyStimulus(($urandom % 8 == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23),
                              ($urandom % 8 == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59),
                              ($urandom % 8 == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59),
                              ($urandom % 2 == 0) ? (1 << $urandom_range(0, 2)) : $urandom_range(0, 7));
            end
            if ($urandom % 800 == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
